// File: rtl/spi_pkg.sv
// Shared SPI command, loader state and bank types for the UART-to-flash path.
// Used by flash_load_ctrl and pp_bank_tracker.
package spi_pkg;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_ERASE = 2'd1,
      CMD_WRITE = 2'd2,
      CMD_END   = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      ST_ERASE = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_END   = 3'd3,
      ST_DONE  = 3'd4
   } load_state_t;

   typedef enum logic {
      BANK_FREE   = 1'b0,
      BANK_LOADED = 1'b1
   } bank_t;

   localparam int BLOCK_SIZE_DEFAULT = 256;

   function automatic cmd_t state_cmd(input load_state_t s);
      cmd_t c;
      unique case (s)
         ST_ERASE: c = CMD_ERASE;
         ST_WRITE: c = CMD_WRITE;
         ST_END:   c = CMD_END;
         default:  c = CMD_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pp_bank_tracker.sv
// Ping-pong bank ownership: commit detection, FREE/LOADED flags, lengths, overrun.
// FLASH_LOAD_CTRL_STATS_EN adds the sticky partial_seen_o output.
module pp_bank_tracker
   import spi_pkg::*;
#(
   parameter int BLOCK_SIZE = BLOCK_SIZE_DEFAULT,
   parameter int LEN_W      = $clog2(BLOCK_SIZE) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fill_full_i,
   input  logic                  fill_timeout_i,
   input  logic [LEN_W-1:0]      fill_count_i,
   input  logic                  commit_en_i,
   input  logic                  drain_free_i,
   output logic                  fill_sel_o,
   output logic                  drain_sel_o,
   output logic                  fill_ready_o,
   output logic [1:0]            loaded_o,
   output logic [1:0][LEN_W-1:0] len_o,
   output logic                  commit_o,
   output logic                  overrun_o
`ifdef FLASH_LOAD_CTRL_STATS_EN
   ,
   output logic                  partial_seen_o
`endif
);

   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BLOCK_SIZE);

   bank_t                  bank_q [2];
   bank_t                  bank_d [2];
   logic [1:0][LEN_W-1:0]  len_q, len_d;
   logic                   fill_sel_q, fill_sel_d;
   logic                   drain_sel_q, drain_sel_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_q;
   logic                   to_edge;
   logic                   commit_ok;
   logic [LEN_W-1:0]       commit_len;

   assign to_edge      = fill_timeout_i & ~timeout_q & (fill_count_i != '0);
   assign commit_o     = fill_full_i | to_edge;
   assign commit_len   = fill_full_i ? FULL_LEN : fill_count_i;
   assign fill_ready_o = (bank_q[fill_sel_q] == BANK_FREE);
   assign commit_ok    = commit_en_i & commit_o & fill_ready_o;

   // A bank freed this cycle only becomes visible to commits next cycle.
   always_comb begin
      bank_d      = bank_q;
      len_d       = len_q;
      fill_sel_d  = fill_sel_q;
      drain_sel_d = drain_sel_q;
      overrun_d   = overrun_q;
      if (drain_free_i) begin
         bank_d[drain_sel_q] = BANK_FREE;
         drain_sel_d         = ~drain_sel_q;
      end
      if (commit_ok) begin
         bank_d[fill_sel_q] = BANK_LOADED;
         len_d[fill_sel_q]  = commit_len;
         fill_sel_d         = ~fill_sel_q;
      end
      if (commit_en_i && commit_o && !fill_ready_o) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bank_q      <= '{BANK_FREE, BANK_FREE};
         len_q       <= {FULL_LEN, FULL_LEN};
         fill_sel_q  <= 1'b0;
         drain_sel_q <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         len_q       <= len_d;
         fill_sel_q  <= fill_sel_d;
         drain_sel_q <= drain_sel_d;
         overrun_q   <= overrun_d;
         timeout_q   <= fill_timeout_i;
      end
   end

`ifdef FLASH_LOAD_CTRL_STATS_EN
   logic partial_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         partial_q <= 1'b0;
      end else if (commit_ok && (commit_len < FULL_LEN)) begin
         partial_q <= 1'b1;
      end
   end

   assign partial_seen_o = partial_q;
`endif

   assign loaded_o    = {bank_q[1] == BANK_LOADED, bank_q[0] == BANK_LOADED};
   assign len_o       = len_q;
   assign fill_sel_o  = fill_sel_q;
   assign drain_sel_o = drain_sel_q;
   assign overrun_o   = overrun_q;

endmodule

// File: rtl/flash_load_ctrl.sv
// UART-to-SPI-flash load sequencer: ERASE -> WRITE* -> END over ping-pong banks.
// FLASH_LOAD_CTRL_STATS_EN adds blocks_written and partial_seen outputs.
module flash_load_ctrl
   import spi_pkg::*;
#(
   parameter int                BLOCK_SIZE = BLOCK_SIZE_DEFAULT,
   parameter int                ADDR_W     = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                LEN_W      = $clog2(BLOCK_SIZE) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_full,
   input  logic              fill_timeout,
   input  logic [LEN_W-1:0]  fill_count,
   output logic              fill_sel,
   output logic              fill_ready,
   output logic              drain_sel,
   output cmd_t              spi_cmd,
   input  logic              spi_done,
   output logic [ADDR_W-1:0] spi_addr,
   output logic [LEN_W-1:0]  spi_len,
   output logic              overrun,
   output logic              load_done
`ifdef FLASH_LOAD_CTRL_STATS_EN
   ,
   output logic [ADDR_W-1:0] blocks_written,
   output logic              partial_seen
`endif
);

   localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(BLOCK_SIZE);
   localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BLOCK_SIZE);

   load_state_t           state_q, state_d;
   cmd_t                  spi_cmd_q;
   logic [ADDR_W-1:0]     spi_addr_q, spi_addr_d;
   logic [LEN_W-1:0]      spi_len_q, spi_len_d;
   logic                  written_any_q, written_any_d;
   logic                  load_done_q;
   logic                  drain_free;
   logic                  commit;
   logic                  len_sel;
   logic [1:0]            loaded;
   logic [1:0][LEN_W-1:0] len;

   assign drain_free = (state_q == ST_WRITE) && spi_done;

   pp_bank_tracker #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .LEN_W      (LEN_W)
   ) u_banks (
      .clk_i          (clk),
      .rst_i          (rst),
      .fill_full_i    (fill_full),
      .fill_timeout_i (fill_timeout),
      .fill_count_i   (fill_count),
      .commit_en_i    (state_q != ST_DONE),
      .drain_free_i   (drain_free),
      .fill_sel_o     (fill_sel),
      .drain_sel_o    (drain_sel),
      .fill_ready_o   (fill_ready),
      .loaded_o       (loaded),
      .len_o          (len),
      .commit_o       (commit),
      .overrun_o      (overrun)
`ifdef FLASH_LOAD_CTRL_STATS_EN
      ,
      .partial_seen_o (partial_seen)
`endif
   );

   // Back-to-back only on a bank already loaded; a same-cycle commit waits in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ERASE: begin
            if (spi_done) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (loaded[drain_sel]) begin
               state_d = ST_WRITE;
            end else if (fill_timeout && written_any_q &&
                         (loaded == 2'b00) && !commit) begin
               state_d = ST_END;
            end
         end
         ST_WRITE: begin
            if (spi_done) begin
               state_d = loaded[~drain_sel] ? ST_WRITE : ST_IDLE;
            end
         end
         ST_END: begin
            if (spi_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_ERASE;
         end
      endcase
   end

   assign len_sel = drain_sel ^ (state_q == ST_WRITE);

   always_comb begin
      spi_addr_d    = spi_addr_q;
      spi_len_d     = spi_len_q;
      written_any_d = written_any_q | drain_free;
      if (drain_free) begin
         spi_addr_d = spi_addr_q + ADDR_INC;
      end
      if ((state_d == ST_WRITE) && ((state_q != ST_WRITE) || spi_done)) begin
         spi_len_d = len[len_sel];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_ERASE;
         spi_cmd_q     <= CMD_ERASE;
         spi_addr_q    <= BASE_ADDR;
         spi_len_q     <= FULL_LEN;
         written_any_q <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         spi_cmd_q     <= state_cmd(state_d);
         spi_addr_q    <= spi_addr_d;
         spi_len_q     <= spi_len_d;
         written_any_q <= written_any_d;
         load_done_q   <= (state_d == ST_DONE);
      end
   end

`ifdef FLASH_LOAD_CTRL_STATS_EN
   logic [ADDR_W-1:0] blocks_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blocks_q <= '0;
      end else if (drain_free) begin
         blocks_q <= blocks_q + ADDR_W'(1);
      end
   end

   assign blocks_written = blocks_q;
`endif

   assign spi_cmd   = spi_cmd_q;
   assign spi_addr  = spi_addr_q;
   assign spi_len   = spi_len_q;
   assign load_done = load_done_q;

endmodule

// File: doc/flash_load_ctrl.md
Name: flash_load_ctrl

Overview:
- Sequencer for the UART-to-SPI-flash bootstrap path.
- Owns the two-buffer ping-pong RAM handoff: which buffer UART fills, which buffer SPI drains.
- Issues the SPI command stream ERASE -> WRITE* -> END, with per-block flash address and length.
- Replaces ad-hoc toggle/address glue in the top level.
- Sits between uart (fill side), the two ram instances (bank select) and spi (command side).

Parameters:
- BLOCK_SIZE, 256: bytes per flash program block. Power of two.
- ADDR_W, 24: flash address width.
- BASE_ADDR, 0: flash address of the first block.
- LEN_W, $clog2(BLOCK_SIZE)+1: width of the block-length field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fill_full  in  1  one-cycle pulse: UART completed a full block
- fill_timeout  in  1  level: UART line idle
- fill_count  in  LEN_W  bytes currently in the fill buffer
- fill_sel  out  1  bank that UART writes
- fill_ready  out  1  fill bank is free; UART may write
- drain_sel  out  1  bank that SPI reads
- spi_cmd  out  spi_pkg::cmd_t  current command to spi
- spi_done  in  1  one-cycle pulse: spi finished the current command
- spi_addr  out  ADDR_W  flash address for the WRITE
- spi_len  out  LEN_W  valid bytes in the drained block
- overrun  out  1  sticky: commit attempted while no bank free
- load_done  out  1  END completed

Behaviour:
- Reset values:
  - state=ERASE, spi_cmd=ERASE, fill_sel=0, drain_sel=0, fill_ready=1.
  - spi_addr=BASE_ADDR, spi_len=BLOCK_SIZE, overrun=0, load_done=0.
  - Both banks FREE; written_any=0.
  - Reset mid-operation abandons everything and restarts at ERASE.
- Commit event (fill side):
  - Fires on fill_full, or on a rising edge of fill_timeout (registered previous value) with fill_count != 0.
  - Timeout edge with fill_count == 0 is not a commit.
  - On commit with fill_ready=1: mark bank[fill_sel] LOADED, latch len[fill_sel] (BLOCK_SIZE for full, fill_count for timeout), toggle fill_sel next cycle.
  - On commit with fill_ready=0: set overrun; bank state unchanged.
- fill_ready = (bank[fill_sel] == FREE).
- FSM; spi_cmd is registered and equals the state's command; spi_done is the only advance for ERASE/WRITE/END:
  - ERASE: cmd=ERASE. On spi_done -> IDLE.
  - IDLE: cmd=NONE.
    - bank[drain_sel] LOADED -> WRITE.
    - Else if fill_timeout && written_any && both banks FREE && no commit this cycle -> END.
  - WRITE: cmd=WRITE; spi_addr and spi_len held stable. On spi_done:
    - bank[drain_sel] -> FREE; toggle drain_sel.
    - spi_addr += BLOCK_SIZE, wrapping mod 2^ADDR_W.
    - written_any=1.
    - Next state: WRITE if the other bank is LOADED (back-to-back, no IDLE cycle), else IDLE.
  - END: cmd=END. On spi_done -> DONE.
  - DONE: cmd=NONE, load_done=1. Terminal until rst. Commits are ignored and do not set overrun.
- spi_len = len[drain_sel]. It is updated on entry to WRITE.
- Simultaneous events:
  - Commit and WRITE spi_done in the same cycle both apply.
  - A bank freed this cycle is not reusable by a commit in the same cycle; fill_ready reflects it next cycle.
- spi_done in IDLE or DONE is ignored.
- Latency:
  - Commit to WRITE cmd: 2 cycles if idle.
  - spi_done to next cmd: 1 cycle.

Optional Feature:
- Macro: FLASH_LOAD_CTRL_STATS_EN.
- Defined:
  - Adds output blocks_written [ADDR_W-1:0], incremented on every WRITE spi_done and reset to 0.
  - Adds output partial_seen, sticky, set when a committed length < BLOCK_SIZE.
- Undefined: both ports and their logic are absent.
- Core behaviour is identical either way.

Decomposition:
- spi_pkg gains:
  - load_state_t enum {ERASE, IDLE, WRITE, END, DONE}
  - BLOCK_SIZE_DEFAULT constant
- cmd_t stays in spi_pkg.
- Sub-module pp_bank_tracker: two FREE/LOADED flags, fill_sel/drain_sel, len registers, and commit/free/overrun logic. The FSM stays in flash_load_ctrl.

Test Plan:
- Reset, spi_done pulse at cycle 5 -> spi_cmd ERASE then NONE; fill_ready=1; spi_addr=0x000000.
- Two fill_full pulses 3 cycles apart, spi_done after 20 cycles each:
  - WRITE addr 0x000000 len 256 on bank 0.
  - Then WRITE 0x000100 on bank 1 with no IDLE cycle between.
  - drain_sel 0->1->0.
- Third fill_full while both banks are LOADED -> overrun=1, fill_ready=0, no bank state change; subsequent writes are unaffected.
- fill_timeout rises with fill_count=37 after one full block:
  - WRITE len 37 at 0x000100.
  - After its spi_done with timeout still high -> END.
  - After END's spi_done -> load_done=1.
- Commit coincident with WRITE spi_done -> both take effect; next WRITE starts 1 cycle later with the correct bank and address.
- Force spi_addr near 0xFFFF00 with BASE_ADDR=0xFFFF00, two blocks -> second address 0x000000 (wrap). rst asserted mid-WRITE -> ERASE, all outputs at reset values next cycle.
